// File: rtl/lsu_pkg.sv
// lsu_pkg: shared funct3 codes, FSM state type and word width for the load/store initiator
package lsu_pkg;
    localparam int WORD_W = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} lsu_state_e;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extraction with sign/zero extension and store lane merge into a word
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]        i_funct3,
    input  logic [1:0]        i_addr_lo,
    input  logic [WORD_W-1:0] i_rdata,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load,
    output logic [WORD_W-1:0] o_merge
);
    logic [4:0]        w_sh;
    logic [WORD_W-1:0] w_lane;
    logic [WORD_W-1:0] w_mask;
    logic              w_sx;
    // shift the addressed lane down for loads; build byte/half mask at the lane for stores
    always_comb begin
        w_sh    = {i_addr_lo, 3'b000};
        w_lane  = i_rdata >> w_sh;
        w_sx    = ~i_funct3[2];
        w_mask  = i_funct3[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        o_load  = (i_funct3[1:0] == 2'b00) ? {{24{w_sx & w_lane[7]}}, w_lane[7:0]} :
                  (i_funct3[1:0] == 2'b01) ? {{16{w_sx & w_lane[15]}}, w_lane[15:0]} : i_rdata;
        o_merge = (i_rdata & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
    end
endmodule

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: RV32I load/store initiator for a word-wide data memory with RMW for SB/SH.
// Optional macro LSU_MISALIGN_EN: misaligned halfword/word accesses report an error instead of
// being truncated to natural alignment.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int BYTES = 2048
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [31:0]       i_req_addr,
    input  logic [WORD_W-1:0] i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [WORD_W-1:0] o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_mem_we,
    output logic              o_mem_re,
    output logic [31:0]       o_mem_addr,
    output logic [WORD_W-1:0] o_mem_wdata,
    input  logic [WORD_W-1:0] i_mem_rdata
);
    localparam logic [29:0] WORDS = 30'(BYTES / 4);

    lsu_state_e        r_state, w_next;
    logic              r_we, r_err;
    logic [2:0]        r_f3;
    logic [31:0]       r_addr;
    logic [WORD_W-1:0] r_wdata, r_rdata;
    logic [WORD_W-1:0] w_load, w_merge;
    logic [31:0]       w_aligned;
    logic              w_f3_bad, w_range, w_mis, w_err, w_acc;

    assign w_f3_bad  = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11) ||
                       (i_req_we && i_req_funct3[2]);
    assign w_range   = i_req_addr[31:2] >= WORDS;
`ifdef LSU_MISALIGN_EN
    assign w_mis     = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    assign w_mis     = 1'b0;
`endif
    assign w_err     = w_f3_bad | w_range | w_mis;
    assign w_acc     = (r_state == S_IDLE) && i_req_valid;
    assign w_aligned = i_req_funct3[1] ? {i_req_addr[31:2], 2'b00} :
                       i_req_funct3[0] ? {i_req_addr[31:1], 1'b0} : i_req_addr;

    lsu_lane_align u_align (
        .i_funct3  (r_f3),
        .i_addr_lo (r_addr[1:0]),
        .i_rdata   (i_mem_rdata),
        .i_wdata   (r_wdata),
        .o_load    (w_load),
        .o_merge   (w_merge)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // next state and memory/response outputs; memory strobes are killed while reset is asserted
    always_comb begin
        w_next      = r_state;
        o_req_ready = (r_state == S_IDLE);
        o_mem_re    = ((r_state == S_RD) || (r_state == S_RMW_RD)) && !i_rst;
        o_mem_we    = (r_state == S_WR) && !i_rst;
        o_mem_addr  = (r_state == S_RD || r_state == S_RMW_RD || r_state == S_WR) ?
                      {r_addr[31:2], 2'b00} : 32'h0;
        o_mem_wdata = (r_state == S_WR) ? r_wdata : '0;
        o_rsp_valid = (r_state == S_RESP);
        o_rsp_rdata = (r_state == S_RESP) ? r_rdata : '0;
        o_rsp_err   = (r_state == S_RESP) && r_err;
        case (r_state)
            S_IDLE:   if (i_req_valid) w_next = w_err ? S_RESP : !i_req_we ? S_RD :
                                                (i_req_funct3 == F3_W) ? S_WR : S_RMW_RD;
            S_RD:     w_next = S_RESP;
            S_RMW_RD: w_next = S_WR;
            S_WR:     w_next = S_RESP;
            S_RESP:   if (i_rsp_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // latch the request on accept, capture load data in RD and the merged word in RMW_RD
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_f3    <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            if (w_acc) begin
                r_we    <= i_req_we;
                r_err   <= w_err;
                r_f3    <= i_req_funct3;
                r_addr  <= w_aligned;
                r_wdata <= i_req_wdata;
                r_rdata <= '0;
            end
            if (r_state == S_RD && !r_we) r_rdata <= w_load;
            if (r_state == S_RMW_RD)      r_wdata <= w_merge;
        end
    end
endmodule
